cond_unit: RTL and testbench
============================

# cond_unit

Registered condition-check unit sitting downstream of the 32-bit ALU, consuming its N/Z/C/V flags. It holds the architectural flag register, evaluates each instruction's 4-bit condition field against the stored flags, and gates that instruction's register-write, memory-write and PC-source controls. Instructions enter and leave through valid/ready handshakes with one cycle of latency, so the unit can sit between the execute and writeback stages.

## Interface
- CNT_W, 16, width of the squash counter (used only with COND_STATS_EN)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  unit can accept this cycle
- cond  in  4  condition field
- flag_w  in  2  bit1: update N,Z; bit0: update C,V
- alu_flags  in  4  {N,Z,C,V} produced by the ALU for this instruction
- reg_write_in, mem_write_in, pc_src_in  in  1 each  ungated controls
- flush  in  1  discard the in-flight instruction and the current input
- out_valid  out  1  gated controls valid
- out_ready  in  1  downstream accepts
- reg_write_out, mem_write_out, pc_src_out  out  1 each  gated controls
- cond_ex  out  1  condition passed for the output instruction
- flags_q  out  4  current flag register {N,Z,C,V}
- squash_cnt  out  CNT_W  only present with COND_STATS_EN

## Operation
- Accept = in_valid & in_ready & ~flush. in_ready = ~out_valid | out_ready. Combinational; it does not depend on in_valid.
- Condition evaluation uses flags_q as it stands before the accept edge:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 and 1111: always true
- On accept with condition true:
  - flag_w[1] loads N,Z from alu_flags.
  - flag_w[0] loads C,V from alu_flags.
  - Output registers load the input controls, and cond_ex=1.
- On accept with condition false:
  - flags_q is unchanged.
  - The three control outputs load 0, and cond_ex=0.
  - out_valid is still asserted, so a squashed instruction still retires.
- out_valid:
  - Set on accept.
  - Cleared on out_valid & out_ready when there is no accept.
  - Held when out_valid & ~out_ready.
- flush=1 (synchronous):
  - Next cycle out_valid=0.
  - There is no flag update and no counter update for the input presented that cycle.
  - flush takes priority over accept and over the output handshake.

## Timing
- Reset (asynchronous, on rst_n low) forces flags_q=0000, out_valid=0, all control outputs and cond_ex to 0, and squash_cnt=0. in_ready=1 during and after reset.
- Latency is one cycle from the accept edge to out_valid. Throughput is one instruction per cycle while out_ready=1.
- Back-to-back: instruction k+1 evaluates against the flags written by instruction k at the previous edge. No bubble is required.
- Stall: while out_valid & ~out_ready, the following hold:
  - in_ready=0.
  - Outputs and flags_q are stable.
  - The input must be held by the producer.
- Simultaneous output handshake and accept: the output registers reload and out_valid stays 1.
- Reset asserted mid-stall discards the held output. Only the reset values remain.

## Configuration
- COND_STATS_EN defined: the port squash_cnt[CNT_W-1:0] exists.
  - Increments by 1 on every accept whose condition is false.
  - Saturates at all-ones and never wraps.
  - Flushed inputs are not counted.
- COND_STATS_EN undefined: the port and the counter are absent, and the rest of the behaviour is identical.

## Test plan
- Reset then idle -> flags_q=0000, out_valid=0, in_ready=1. Accept cond=0000 (EQ) -> cond_ex=0, all controls 0, out_valid=1 next cycle.
- Accept cond=1110, flag_w=11, alu_flags=0100, reg_write_in=1. Then next cycle accept cond=0000, reg_write_in=1 -> first output cond_ex=1, flags_q=0100. Second output cond_ex=1, reg_write_out=1.
- With flags_q=1000 (N=1, V=0): cond=1011 (LT) -> cond_ex=1; cond=1010 (GE) -> cond_ex=0 with flag_w=11 and alu_flags=0000, and flags_q stays 1000.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and outputs stable. Then raise out_ready with in_valid=1 -> simultaneous retire and accept, out_valid stays 1.
- Assert flush on a cycle with in_valid=1, flag_w=11 -> out_valid=0 next cycle, flags_q unchanged, squash_cnt unchanged.
- With COND_STATS_EN and CNT_W=4, issue 17 failing instructions -> squash_cnt reads 15 and does not wrap. Pulse rst_n low -> squash_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cond_unit.sv
// Condition-check stage: holds the N/Z/C/V flag register, evaluates the condition field and gates controls.
// Optional squash counter port squash_cnt is present only when COND_STATS_EN is defined.
module cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       cond,
   input  logic [1:0]       flag_w,
   input  logic [3:0]       alu_flags,
   input  logic             reg_write_in,
   input  logic             mem_write_in,
   input  logic             pc_src_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             reg_write_out,
   output logic             mem_write_out,
   output logic             pc_src_out,
   output logic             cond_ex,
   output logic [3:0]       flags_q
`ifdef COND_STATS_EN
   ,
   output logic [CNT_W-1:0] squash_cnt
`endif
);

   typedef enum logic [3:0] {
      C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
      C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
      C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
      C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
   } cond_e;

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (cond_e'(c))
         C_EQ:    return z;
         C_NE:    return ~z;
         C_CS:    return cy;
         C_CC:    return ~cy;
         C_MI:    return n;
         C_PL:    return ~n;
         C_VS:    return v;
         C_VC:    return ~v;
         C_HI:    return cy & ~z;
         C_LS:    return ~cy | z;
         C_GE:    return n == v;
         C_LT:    return n != v;
         C_GT:    return ~z & (n == v);
         C_LE:    return z | (n != v);
         default: return 1'b1;
      endcase
   endfunction

   logic       out_valid_q, out_valid_d;
   logic       reg_write_q, reg_write_d;
   logic       mem_write_q, mem_write_d;
   logic       pc_src_q,    pc_src_d;
   logic       cond_ex_q,   cond_ex_d;
   logic [3:0] flags_d;
   logic       accept;
   logic       pass;

   assign in_ready = ~out_valid_q | out_ready;
   assign accept   = in_valid & in_ready & ~flush;
   assign pass     = cond_pass(cond, flags_q);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      out_valid_d = out_valid_q;
      reg_write_d = reg_write_q;
      mem_write_d = mem_write_q;
      pc_src_d    = pc_src_q;
      cond_ex_d   = cond_ex_q;
      flags_d     = flags_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         cond_ex_d   = pass;
         reg_write_d = pass & reg_write_in;
         mem_write_d = pass & mem_write_in;
         pc_src_d    = pass & pc_src_in;
         if (pass && flag_w[1]) flags_d[3:2] = alu_flags[3:2];
         if (pass && flag_w[0]) flags_d[1:0] = alu_flags[1:0];
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         reg_write_q <= 1'b0;
         mem_write_q <= 1'b0;
         pc_src_q    <= 1'b0;
         cond_ex_q   <= 1'b0;
         flags_q     <= 4'b0000;
      end else begin
         out_valid_q <= out_valid_d;
         reg_write_q <= reg_write_d;
         mem_write_q <= mem_write_d;
         pc_src_q    <= pc_src_d;
         cond_ex_q   <= cond_ex_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign reg_write_out = reg_write_q;
   assign mem_write_out = mem_write_q;
   assign pc_src_out    = pc_src_q;
   assign cond_ex       = cond_ex_q;

`ifdef COND_STATS_EN
   logic [CNT_W-1:0] squash_q, squash_d;

   // Saturating count of squashed (condition-false) accepts; flushed inputs never reach accept.
   always_comb begin
      squash_d = squash_q;
      if (accept && !pass && squash_q != {CNT_W{1'b1}}) squash_d = squash_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) squash_q <= '0;
      else        squash_q <= squash_d;
   end

   assign squash_cnt = squash_q;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: flag/condition model compared every cycle plus literal spot checks.
// Build with COND_STATS_EN defined to also exercise the squash counter.
module tb_cond_unit;
   localparam int CNT_W   = 4;
   localparam int SQ_MAX  = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, flush, out_valid, out_ready;
   logic [3:0] cond, alu_flags, flags_q;
   logic [1:0] flag_w;
   logic       reg_write_in, mem_write_in, pc_src_in;
   logic       reg_write_out, mem_write_out, pc_src_out, cond_ex;
`ifdef COND_STATS_EN
   logic [CNT_W-1:0] squash_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cond_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .cond(cond), .flag_w(flag_w), .alu_flags(alu_flags),
      .reg_write_in(reg_write_in), .mem_write_in(mem_write_in), .pc_src_in(pc_src_in),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .reg_write_out(reg_write_out), .mem_write_out(mem_write_out), .pc_src_out(pc_src_out),
      .cond_ex(cond_ex), .flags_q(flags_q)
`ifdef COND_STATS_EN
      , .squash_cnt(squash_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural model: flags as named bits, one pending output slot, integer squash count.
   logic m_n, m_z, m_c, m_v;
   logic m_valid, m_rw, m_mw, m_pc, m_cex;
   int   m_sq;

   function automatic logic model_pass(input logic [3:0] c);
      logic base;
      if (c[3:1] == 3'b111) return 1'b1;
      case (c[3:1])
         3'd0:    base = m_z;
         3'd1:    base = m_c;
         3'd2:    base = m_n;
         3'd3:    base = m_v;
         3'd4:    base = m_c && !m_z;
         3'd5:    base = (m_n == m_v);
         default: base = !m_z && (m_n == m_v);
      endcase
      return base ^ c[0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {m_n, m_z, m_c, m_v} = 4'b0000;
         {m_valid, m_rw, m_mw, m_pc, m_cex} = 5'b0;
         m_sq = 0;
      end else begin
         logic acc, ok;
         acc = in_valid && (!m_valid || out_ready) && !flush;
         ok  = model_pass(cond);
         if (flush) m_valid = 1'b0;
         else if (acc) begin
            m_valid = 1'b1;
            m_cex   = ok;
            m_rw    = ok && reg_write_in;
            m_mw    = ok && mem_write_in;
            m_pc    = ok && pc_src_in;
            if (ok) begin
               if (flag_w[1]) begin m_n = alu_flags[3]; m_z = alu_flags[2]; end
               if (flag_w[0]) begin m_c = alu_flags[1]; m_v = alu_flags[0]; end
            end else if (m_sq < SQ_MAX) m_sq++;
         end else if (out_ready) m_valid = 1'b0;
      end
   end

   // Single compare process, away from the active edge.
   always @(negedge clk) begin
      check("in_ready", in_ready, !m_valid || out_ready);
      check("flags_q", flags_q, {m_n, m_z, m_c, m_v});
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
         check("cond_ex", cond_ex, m_cex);
         check("reg_write_out", reg_write_out, m_rw);
         check("mem_write_out", mem_write_out, m_mw);
         check("pc_src_out", pc_src_out, m_pc);
      end
`ifdef COND_STATS_EN
      check("squash_cnt", squash_cnt, m_sq);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic v, input logic [3:0] c, input logic [1:0] fw,
                        input logic [3:0] af, input logic rw, input logic mw, input logic pc);
      in_valid = v; cond = c; flag_w = fw; alu_flags = af;
      reg_write_in = rw; mem_write_in = mw; pc_src_in = pc;
   endtask

   initial begin
      logic [3:0] flag_set [5];
      flag_set = '{4'b0000, 4'b0110, 4'b1001, 4'b0101, 4'b1111};
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      issue(0, 4'd0, 2'b00, 4'd0, 0, 0, 0);
      #3;
      check("lit_reset_in_ready", in_ready, 1);
      check("lit_reset_out_valid", out_valid, 0);
      #9 rst_n = 1'b1;
      tick();
      check("lit_idle_flags", flags_q, 4'b0000);
      check("lit_idle_in_ready", in_ready, 1);

      // EQ with Z=0 squashes
      issue(1, 4'b0000, 2'b00, 4'd0, 1, 1, 1); tick();
      check("lit_eq_valid", out_valid, 1);
      check("lit_eq_cex", cond_ex, 0);
      check("lit_eq_ctrl", {reg_write_out, mem_write_out, pc_src_out}, 3'b000);

      // Back-to-back: flags written by AL feed the next EQ
      issue(1, 4'b1110, 2'b11, 4'b0100, 1, 0, 0); tick();
      check("lit_al_cex", cond_ex, 1);
      check("lit_al_flags", flags_q, 4'b0100);
      issue(1, 4'b0000, 2'b00, 4'd0, 1, 0, 0); tick();
      check("lit_b2b_cex", cond_ex, 1);
      check("lit_b2b_rw", reg_write_out, 1);

      // N=1, V=0: LT passes, GE fails without touching flags
      issue(1, 4'b1110, 2'b11, 4'b1000, 0, 0, 0); tick();
      issue(1, 4'b1011, 2'b00, 4'd0, 0, 0, 0); tick();
      check("lit_lt_cex", cond_ex, 1);
      issue(1, 4'b1010, 2'b11, 4'b0000, 1, 1, 1); tick();
      check("lit_ge_cex", cond_ex, 0);
      check("lit_ge_flags", flags_q, 4'b1000);

      // Stall for 3 cycles, then simultaneous retire and accept
      issue(1, 4'b1110, 2'b11, 4'b1001, 1, 0, 1); tick();
      out_ready = 1'b0;
      issue(1, 4'b0000, 2'b00, 4'd0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lit_stall_in_ready", in_ready, 0);
         check("lit_stall_hold", {out_valid, reg_write_out, pc_src_out, cond_ex, flags_q}, 8'b1111_1001);
      end
      out_ready = 1'b1; tick();
      check("lit_retire_accept_valid", out_valid, 1);
      check("lit_retire_accept_cex", cond_ex, 0);

      // Flush beats accept: no flag update, no count
      issue(1, 4'b1110, 2'b11, 4'b1111, 1, 1, 1); flush = 1'b1; tick();
      flush = 1'b0;
      check("lit_flush_valid", out_valid, 0);
      check("lit_flush_flags", flags_q, 4'b1001);
`ifdef COND_STATS_EN
      check("lit_flush_sq", squash_cnt, 3);
`endif

      // 17 failing instructions drive the counter into saturation
      for (int i = 0; i < 17; i++) begin
         issue(1, 4'b0000, 2'b11, 4'b0000, 1, 1, 1); tick();
      end
      check("lit_sat_flags", flags_q, 4'b1001);
`ifdef COND_STATS_EN
      check("lit_sat_sq", squash_cnt, 15);
`endif

      // Every condition against several flag patterns, with occasional backpressure
      foreach (flag_set[k]) begin
         out_ready = 1'b1;
         issue(1, 4'b1110, 2'b11, flag_set[k], 0, 0, 0); tick();
         for (int c = 0; c < 16; c++) begin
            out_ready = (c % 5 != 4);
            issue(1, 4'(c), 2'b00, 4'd0, 1, c[0], c[1]); tick();
         end
      end

      // Async reset in the middle of a stall
      out_ready = 1'b1;
      issue(1, 4'b1110, 2'b00, 4'd0, 1, 0, 0); tick();
      out_ready = 1'b0; issue(0, 4'd0, 2'b00, 4'd0, 0, 0, 0); tick();
      #1 rst_n = 1'b0;
      #1;
      check("lit_arst_valid", out_valid, 0);
      check("lit_arst_ctrl", {reg_write_out, cond_ex, flags_q}, 6'b0);
      check("lit_arst_in_ready", in_ready, 1);
`ifdef COND_STATS_EN
      check("lit_arst_sq", squash_cnt, 0);
`endif
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
